// File: rtl/reorder_buffer.sv
// Multi-lane reorder buffer: packed in-order allocation, CDB completion, in-order commit of up to
// WIDTH finished entries per cycle, sticky halt and full flush.
module reorder_buffer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned CDB_N  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned AREG_W = 4,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          alloc_valid,
  input  logic [WIDTH*AREG_W-1:0]   alloc_target,
  input  logic [WIDTH-1:0]          alloc_halt,
  output logic                      alloc_ready,
  output logic [WIDTH*IDX_W-1:0]    alloc_idx,
  input  logic [CDB_N-1:0]          cdb_valid,
  input  logic [CDB_N*IDX_W-1:0]    cdb_idx,
  input  logic [CDB_N*DATA_W-1:0]   cdb_data,
  input  logic                      flush,
  output logic [WIDTH-1:0]          commit_valid,
  output logic [WIDTH*AREG_W-1:0]   commit_target,
  output logic [WIDTH*DATA_W-1:0]   commit_data,
  output logic [WIDTH*IDX_W-1:0]    commit_idx,
  output logic                      halted,
  output logic [IDX_W:0]            count,
  output logic [IDX_W-1:0]          head
);

  localparam int unsigned CNT_W = IDX_W + 1;

  logic [CNT_W-1:0]  head_q, tail_q, count_w, n_alloc, n_commit;
  logic [DEPTH-1:0]  valid_q, fin_q, halt_q;
  logic              halted_q, commit_halt;
  logic [WIDTH-1:0]  commit_mask;
  logic [IDX_W-1:0]  aidx [WIDTH];
  logic [IDX_W-1:0]  cidx [WIDTH];
  logic [AREG_W-1:0] target_q [DEPTH];
  logic [DATA_W-1:0] value_q [DEPTH];

  assign count_w     = head_q - tail_q;
  assign count       = count_w;
  assign head        = head_q[IDX_W-1:0];
  assign halted      = halted_q;
  assign alloc_ready = ((CNT_W'(DEPTH) - count_w) >= CNT_W'(WIDTH)) && !halted_q;

  // Lanes are packed: each valid lane takes the next slot after the valid lanes below it.
  always_comb begin
    logic [CNT_W-1:0] offs;
    offs      = '0;
    alloc_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      aidx[i] = head_q[IDX_W-1:0] + offs[IDX_W-1:0];
      alloc_idx[i*IDX_W +: IDX_W] = aidx[i];
      if (alloc_valid[i]) offs = offs + CNT_W'(1);
    end
    n_alloc = offs;
  end

  // Commit window walks from tail; it stops at the first unfinished entry or just past a halt.
  always_comb begin
    logic go;
    go          = !halted_q;
    commit_mask = '0;
    n_commit    = '0;
    commit_halt = 1'b0;
    for (int j = 0; j < WIDTH; j++) begin
      cidx[j] = tail_q[IDX_W-1:0] + IDX_W'(j);
      go = go && (CNT_W'(j) < count_w) && fin_q[cidx[j]];
      commit_mask[j] = go;
      if (go) n_commit = n_commit + CNT_W'(1);
      if (go && halt_q[cidx[j]]) begin
        commit_halt = 1'b1;
        go          = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= '0;
      tail_q       <= '0;
      valid_q      <= '0;
      fin_q        <= '0;
      halt_q       <= '0;
      halted_q     <= 1'b0;
      commit_valid <= '0;
    end else begin
      commit_valid <= commit_mask;
      tail_q       <= tail_q + n_commit;
      if (commit_halt) halted_q <= 1'b1;
      if (flush) begin
        head_q  <= tail_q + n_commit;
        valid_q <= '0;
        fin_q   <= '0;
        halt_q  <= '0;
      end else begin
        if (alloc_ready) begin
          head_q <= head_q + n_alloc;
          for (int i = 0; i < WIDTH; i++) begin
            if (alloc_valid[i]) begin
              valid_q[aidx[i]] <= 1'b1;
              halt_q[aidx[i]]  <= alloc_halt[i];
              fin_q[aidx[i]]   <= alloc_halt[i];
            end
          end
        end
        for (int k = 0; k < CDB_N; k++) begin
          if (cdb_valid[k] && valid_q[cdb_idx[k*IDX_W +: IDX_W]]) begin
            fin_q[cdb_idx[k*IDX_W +: IDX_W]] <= 1'b1;
          end
        end
        // Retiring entries lose valid last, so a same-cycle CDB hit cannot resurrect them.
        for (int j = 0; j < WIDTH; j++) begin
          if (commit_mask[j]) begin
            valid_q[cidx[j]] <= 1'b0;
            fin_q[cidx[j]]   <= 1'b0;
          end
        end
      end
    end
  end

  // Payload storage is intentionally unreset; only the valid/finished bits gate its use.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (alloc_ready) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (alloc_valid[i]) target_q[aidx[i]] <= alloc_target[i*AREG_W +: AREG_W];
        end
      end
      for (int k = 0; k < CDB_N; k++) begin
        if (cdb_valid[k] && valid_q[cdb_idx[k*IDX_W +: IDX_W]]) begin
          value_q[cdb_idx[k*IDX_W +: IDX_W]] <= cdb_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < WIDTH; j++) begin
      commit_target[j*AREG_W +: AREG_W] <= target_q[cidx[j]];
      commit_data[j*DATA_W +: DATA_W]   <= value_q[cidx[j]];
      commit_idx[j*IDX_W +: IDX_W]      <= cidx[j];
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: queue-based in-order model checked every cycle, directed scenarios
// pinned with literal expectations, then randomized traffic with flushes, halts and resets.
module tb_reorder_buffer;

  localparam int DEPTH  = 16;
  localparam int WIDTH  = 4;
  localparam int CDB_N  = 4;
  localparam int DATA_W = 16;
  localparam int AREG_W = 4;
  localparam int IDX_W  = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [WIDTH-1:0]        alloc_valid, alloc_halt;
  logic [WIDTH*AREG_W-1:0] alloc_target;
  logic                    alloc_ready;
  logic [WIDTH*IDX_W-1:0]  alloc_idx;
  logic [CDB_N-1:0]        cdb_valid;
  logic [CDB_N*IDX_W-1:0]  cdb_idx;
  logic [CDB_N*DATA_W-1:0] cdb_data;
  logic                    flush;
  logic [WIDTH-1:0]        commit_valid;
  logic [WIDTH*AREG_W-1:0] commit_target;
  logic [WIDTH*DATA_W-1:0] commit_data;
  logic [WIDTH*IDX_W-1:0]  commit_idx;
  logic                    halted;
  logic [IDX_W:0]          count;
  logic [IDX_W-1:0]        head;

  reorder_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .CDB_N (CDB_N),
    .DATA_W(DATA_W),
    .AREG_W(AREG_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_valid  (alloc_valid),
    .alloc_target (alloc_target),
    .alloc_halt   (alloc_halt),
    .alloc_ready  (alloc_ready),
    .alloc_idx    (alloc_idx),
    .cdb_valid    (cdb_valid),
    .cdb_idx      (cdb_idx),
    .cdb_data     (cdb_data),
    .flush        (flush),
    .commit_valid (commit_valid),
    .commit_target(commit_target),
    .commit_data  (commit_data),
    .commit_idx   (commit_idx),
    .halted       (halted),
    .count        (count),
    .head         (head)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tgt;
    bit halt;
    bit fin;
    int val;
    int idx;
  } ent_t;

  // Model: program-order queue of outstanding entries plus an unbounded allocation counter.
  ent_t rob[$];
  int   head_abs;
  bit   m_halted;

  int total = 0;
  int bad   = 0;
  logic [WIDTH*IDX_W-1:0] snap_idx;
  logic                   snap_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr();
    alloc_valid  = '0;
    alloc_halt   = '0;
    alloc_target = '0;
    cdb_valid    = '0;
    cdb_idx      = '0;
    cdb_data     = '0;
    flush        = 1'b0;
  endtask

  task automatic set_cdb(input int k, input int idx, input int data);
    cdb_valid[k] = 1'b1;
    cdb_idx[k*IDX_W +: IDX_W]   = IDX_W'(idx);
    cdb_data[k*DATA_W +: DATA_W] = DATA_W'(data);
  endtask

  task automatic do_reset();
    clr();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_ready", alloc_ready, 1);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_halted", halted, 0);
    rob.delete();
    head_abs = 0;
    m_halted = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock cycle with the currently driven inputs; compares DUT against the model.
  task automatic step();
    int sz, pc, ncom, ci;
    bit ready, hnow;
    logic [WIDTH*IDX_W-1:0] eidx;
    logic [WIDTH-1:0] ecv;
    ent_t com [WIDTH];
    ent_t e;
    @(negedge clk);
    sz    = rob.size();
    ready = ((DEPTH - sz) >= WIDTH) && !m_halted;
    chk("alloc_ready", alloc_ready, ready);
    chk("count", count, sz);
    chk("count_bound", count <= DEPTH, 1);
    chk("head", head, head_abs % DEPTH);
    chk("halted", halted, m_halted);
    pc = 0;
    for (int i = 0; i < WIDTH; i++) begin
      eidx[i*IDX_W +: IDX_W] = IDX_W'((head_abs + pc) % DEPTH);
      if (alloc_valid[i]) pc++;
    end
    chk("alloc_idx", alloc_idx, eidx);
    snap_idx   = alloc_idx;
    snap_ready = alloc_ready;

    ecv = '0; ncom = 0; hnow = 1'b0;
    for (int j = 0; j < WIDTH; j++) begin
      if (j >= sz || m_halted || !rob[j].fin) break;
      ecv[j] = 1'b1;
      com[j] = rob[j];
      ncom++;
      if (rob[j].halt) begin
        hnow = 1'b1;
        break;
      end
    end
    if (!flush) begin
      for (int k = 0; k < CDB_N; k++) begin
        if (cdb_valid[k]) begin
          ci = int'(cdb_idx[k*IDX_W +: IDX_W]);
          for (int n = 0; n < rob.size(); n++) begin
            if (rob[n].idx == ci) begin
              e = rob[n];
              e.fin = 1'b1;
              e.val = int'(cdb_data[k*DATA_W +: DATA_W]);
              rob[n] = e;
            end
          end
        end
      end
    end
    repeat (ncom) void'(rob.pop_front());
    if (hnow) m_halted = 1'b1;
    if (flush) begin
      head_abs = head_abs - rob.size();
      rob.delete();
    end else if (ready) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (alloc_valid[i]) begin
          e.tgt  = int'(alloc_target[i*AREG_W +: AREG_W]);
          e.halt = alloc_halt[i];
          e.fin  = alloc_halt[i];
          e.val  = 0;
          e.idx  = head_abs % DEPTH;
          rob.push_back(e);
          head_abs++;
        end
      end
    end

    @(posedge clk);
    #1;
    chk("commit_valid", commit_valid, ecv);
    for (int j = 0; j < WIDTH; j++) begin
      if (ecv[j]) begin
        chk("commit_target", commit_target[j*AREG_W +: AREG_W], com[j].tgt);
        chk("commit_idx", commit_idx[j*IDX_W +: IDX_W], com[j].idx);
        if (!com[j].halt) chk("commit_data", commit_data[j*DATA_W +: DATA_W], com[j].val);
      end
    end
  endtask

  initial begin
    int accepted, prev, cur, nc;
    bit saw_wrap;
    clr();
    head_abs = 0;
    m_halted = 1'b0;

    // Four-lane allocation then out-of-order completion.
    do_reset();
    alloc_valid = 4'b1111; alloc_target = 16'h4321;
    step();
    chk("d1_alloc_idx", snap_idx, 16'h3210);
    chk("d1_count", count, 4);
    clr();
    set_cdb(0, 1, 16'h11); set_cdb(1, 2, 16'h22); set_cdb(2, 3, 16'h33);
    step();
    clr(); step();
    chk("d2_no_commit", commit_valid, 0);
    set_cdb(0, 0, 16'h10);
    step();
    chk("d2_still_none", commit_valid, 0);
    clr(); step();
    chk("d2_commit_all", commit_valid, 4'b1111);
    chk("d2_data", commit_data, 64'h0033_0022_0011_0010);
    chk("d2_count", count, 0);

    // Packed allocation with gaps.
    do_reset();
    alloc_valid = 4'b1111; step();
    alloc_valid = 4'b0001; step();
    alloc_valid = 4'b1010; step();
    chk("d3_lane1", snap_idx[7:4], 5);
    chk("d3_lane3", snap_idx[15:12], 6);
    chk("d3_head", head, 7);

    // Full buffer, stall, drain, then wrap-around traffic.
    do_reset();
    alloc_valid = 4'b1111;
    repeat (4) step();
    step();
    chk("d4_not_ready", snap_ready, 0);
    chk("d4_count_full", count, 16);
    clr();
    for (int k = 0; k < 4; k++) set_cdb(k, k, 16'h100 + k);
    step();
    clr(); step();
    chk("d4_count12", count, 12);
    chk("d4_ready_again", alloc_ready, 1);
    accepted = 0; prev = -1; saw_wrap = 1'b0;
    for (int n = 0; n < 80 && accepted < 40; n++) begin
      clr();
      alloc_valid  = 4'b1111;
      alloc_target = 16'($urandom);
      nc = 0;
      for (int r = 0; r < rob.size() && nc < CDB_N; r++) begin
        if (!rob[r].fin) begin
          set_cdb(nc, rob[r].idx, int'($urandom_range(16'hffff)));
          nc++;
        end
      end
      step();
      if (snap_ready) begin
        accepted += 4;
        for (int i = 0; i < WIDTH; i++) begin
          cur = int'(snap_idx[i*IDX_W +: IDX_W]);
          if (prev == 15 && cur == 0) saw_wrap = 1'b1;
          prev = cur;
        end
      end
    end
    chk("d4_wrap_seen", saw_wrap, 1);

    // Halt in lane 1 stops commit and freezes the buffer.
    do_reset();
    alloc_valid = 4'b1111; alloc_halt = 4'b0010; alloc_target = 16'h8765;
    step();
    clr(); set_cdb(0, 0, 16'haa); set_cdb(1, 2, 16'hbb);
    step();
    clr(); step();
    chk("d5_commit_mask", commit_valid, 4'b0011);
    chk("d5_halted", halted, 1);
    chk("d5_ready", alloc_ready, 0);
    set_cdb(0, 3, 16'hcc); step();
    clr(); repeat (3) step();
    chk("d5_count", count, 2);

    // Flush with one committable entry at tail, then a late CDB to a flushed slot.
    do_reset();
    alloc_valid = 4'b1111; step(); step();
    clr(); set_cdb(0, 0, 16'h55); step();
    clr(); flush = 1'b1; step();
    chk("d6_commit", commit_valid, 4'b0001);
    chk("d6_count", count, 0);
    chk("d6_head", head, 1);
    clr(); set_cdb(0, 3, 16'h77); step();
    clr(); alloc_valid = 4'b1111; step();
    clr(); repeat (3) step();

    // Randomized traffic; each phase starts with a reset taken mid-operation.
    for (int ph = 0; ph < 4; ph++) begin
      do_reset();
      for (int cyc = 0; cyc < 150; cyc++) begin
        clr();
        alloc_valid  = 4'($urandom);
        alloc_target = 16'($urandom);
        for (int i = 0; i < WIDTH; i++) alloc_halt[i] = ($urandom_range(399) == 0);
        for (int k = 0; k < CDB_N; k++) begin
          if ($urandom_range(1) == 1) begin
            if (k > 0 && cdb_valid[k-1] && $urandom_range(7) == 0)
              set_cdb(k, int'(cdb_idx[(k-1)*IDX_W +: IDX_W]), int'($urandom_range(16'hffff)));
            else if (rob.size() > 0 && $urandom_range(3) != 0)
              set_cdb(k, rob[$urandom_range(rob.size()-1)].idx, int'($urandom_range(16'hffff)));
            else
              set_cdb(k, int'($urandom_range(DEPTH-1)), int'($urandom_range(16'hffff)));
          end
        end
        flush = ($urandom_range(39) == 0);
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
